forwarding_unit: RTL and testbench
==================================

Name: forwarding_unit

Overview:
- Data-hazard forwarding control for the pipelined MIPS datapath.
- Compares the two source-register addresses of the instruction entering EX against the destination registers held in the EX/MEM and MEM/WB pipeline registers.
- Produces a 2-bit operand-mux select per ALU operand.
- Selects are registered: sampled on the rising clock edge, cleared by an asynchronous active-low reset.

Parameters:
- REG_W, 4: width of a register address in bits.
- ZERO_REG_FWD, 0: 0 means a destination of register 0 never forwards (hard-wired zero register); 1 means register 0 is treated like any other register.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- IFEXReg1  input  REG_W  source register 1 (rs) of the instruction in the ID/EX stage.
- IFEXReg2  input  REG_W  source register 2 (rt) of the instruction in the ID/EX stage.
- EXMEMReg1  input  REG_W  destination register of the instruction in EX/MEM.
- MEMWBReg1  input  REG_W  destination register of the instruction in MEM/WB.
- WriteEnable  input  1  register-write enable qualifying both the EX/MEM and MEM/WB destinations.
- out1  output  2  forwarding select for ALU operand 1.
- out2  output  2  forwarding select for ALU operand 2.

Behaviour:
- Select encoding:
  - 2'b00: use the register-file value (no forward).
  - 2'b10: forward the EX/MEM ALU result.
  - 2'b01: forward the MEM/WB write-back value.
  - 2'b11: never produced.
- Per operand n (n = 1, 2), with src = IFEXRegn, evaluated combinationally as next_outn:
  - exHit = WriteEnable && (EXMEMReg1 == src) && (ZERO_REG_FWD || EXMEMReg1 != 0).
  - wbHit = WriteEnable && (MEMWBReg1 == src) && (ZERO_REG_FWD || MEMWBReg1 != 0).
  - next_outn = exHit ? 2'b10 : (wbHit ? 2'b01 : 2'b00).
- Priority: when both stages match the same source, EX/MEM wins (most recent producer) and the result is 2'b10.
- The two operands are decoded independently with identical logic. Both operands may select the same source simultaneously.
- Comparisons are exact equality over all REG_W bits; there is no masking or partial compare.
- Registering: on each rising clk edge with rst high, out1 <= next_out1 and out2 <= next_out2. The latency is one cycle from a stable input to a valid output.
- Reset: while rst is low, out1 = 2'b00 and out2 = 2'b00 immediately, independent of the clock. The first update after reset deasserts happens on the next rising edge.
- Reset asserted mid-operation: outputs go to 00 asynchronously. Input values present before or during reset are not remembered.
- Inputs that change between edges do not affect the outputs until the next rising edge. No glitches propagate to out1 or out2.
- If WriteEnable = 0, both selects are 00 on the next edge, regardless of address matches.
- There is no other internal state.

Test Plan:
- Reset: drive rst=0 with arbitrary matching inputs -> out1=00 and out2=00 immediately. Release rst; the next edge loads the decoded values.
- MEM/WB on operand 2: EXMEMReg1=3, IFEXReg1=1, IFEXReg2=7, MEMWBReg1=7, WE=1, one edge -> out1=00, out2=01.
- EX/MEM on operand 1: EXMEMReg1=1, IFEXReg1=1, IFEXReg2=7, MEMWBReg1=7, WE=1 -> out1=10, out2=01.
- MEM/WB on operand 1 and priority:
  - EXMEMReg1=2, IFEXReg1=1, MEMWBReg1=1, IFEXReg2=7 -> out1=01, out2=00.
  - Then EXMEMReg1=5, MEMWBReg1=5, IFEXReg1=5, IFEXReg2=5 -> out1=10, out2=10 (EX/MEM wins).
- No hazard and write disabled:
  - EXMEMReg1=2, IFEXReg1=1, IFEXReg2=1, MEMWBReg1=3, WE=1 -> 00/00.
  - EXMEMReg1=1, IFEXReg1=1, WE=0 -> 00/00.
- Zero register and latency:
  - With ZERO_REG_FWD=0: EXMEMReg1=0, IFEXReg1=0 -> out1=00.
  - Change inputs mid-cycle: outputs must be unchanged until the next rising edge.

Source files
------------

// File: rtl/forwarding_unit.sv
// Data-hazard forwarding control: compares the ID/EX source registers against the
// EX/MEM and MEM/WB destinations and registers a 2-bit operand-mux select per ALU operand.
module forwarding_unit #(
  parameter int REG_W        = 4,
  parameter int ZERO_REG_FWD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFEXReg1,
  input  logic [REG_W-1:0] IFEXReg2,
  input  logic [REG_W-1:0] EXMEMReg1,
  input  logic [REG_W-1:0] MEMWBReg1,
  input  logic             WriteEnable,
  output logic [1:0]       out1,
  output logic [1:0]       out2
);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EXMEM   = 2'b10;
  localparam logic [1:0] SEL_MEMWB   = 2'b01;

  // A write to register 0 is discarded by the register file, so it must not forward
  // unless the zero register is configured as an ordinary register.
  logic ex_dest_valid;
  logic wb_dest_valid;

  assign ex_dest_valid = WriteEnable && ((ZERO_REG_FWD != 0) || (EXMEMReg1 != '0));
  assign wb_dest_valid = WriteEnable && ((ZERO_REG_FWD != 0) || (MEMWBReg1 != '0));

  logic [REG_W-1:0] src      [2];
  logic [1:0]       sel_next [2];
  logic [1:0]       sel_reg  [2];

  assign src[0] = IFEXReg1;
  assign src[1] = IFEXReg2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic ex_hit;
      logic wb_hit;

      assign ex_hit = ex_dest_valid && (EXMEMReg1 == src[gi]);
      assign wb_hit = wb_dest_valid && (MEMWBReg1 == src[gi]);

      // EX/MEM holds the most recent producer, so it takes priority over MEM/WB.
      always_comb begin
        sel_next[gi] = SEL_REGFILE;
        if (ex_hit) begin
          sel_next[gi] = SEL_EXMEM;
        end else if (wb_hit) begin
          sel_next[gi] = SEL_MEMWB;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sel_reg[gi] <= SEL_REGFILE;
        end else begin
          sel_reg[gi] <= sel_next[gi];
        end
      end
    end
  endgenerate

  assign out1 = sel_reg[0];
  assign out2 = sel_reg[1];

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed self-checking bench for forwarding_unit: one task per scenario, inline checks.
module tb_forwarding_unit;

  localparam int REG_W = 4;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] IFEXReg1;
  logic [REG_W-1:0] IFEXReg2;
  logic [REG_W-1:0] EXMEMReg1;
  logic [REG_W-1:0] MEMWBReg1;
  logic             WriteEnable;
  logic [1:0]       out1;
  logic [1:0]       out2;
  logic [1:0]       zout1;
  logic [1:0]       zout2;

  int checks;
  int failures;

  forwarding_unit #(.REG_W(REG_W), .ZERO_REG_FWD(0)) dut (
    .clk(clk), .rst(rst),
    .IFEXReg1(IFEXReg1), .IFEXReg2(IFEXReg2),
    .EXMEMReg1(EXMEMReg1), .MEMWBReg1(MEMWBReg1),
    .WriteEnable(WriteEnable),
    .out1(out1), .out2(out2)
  );

  forwarding_unit #(.REG_W(REG_W), .ZERO_REG_FWD(1)) dut_zero (
    .clk(clk), .rst(rst),
    .IFEXReg1(IFEXReg1), .IFEXReg2(IFEXReg2),
    .EXMEMReg1(EXMEMReg1), .MEMWBReg1(MEMWBReg1),
    .WriteEnable(WriteEnable),
    .out1(zout1), .out2(zout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] ex, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] wb, input logic we);
    EXMEMReg1   = ex;
    IFEXReg1    = r1;
    IFEXReg2    = r2;
    MEMWBReg1   = wb;
    WriteEnable = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(4'd5, 4'd5, 4'd5, 4'd5, 1'b1);
    #2;
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL reset_immediate: out1=%b out2=%b required 00/00", out1, out2);
    end
    step();
    step();
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL reset_held: out1=%b out2=%b required 00/00", out1, out2);
    end
    rst = 1'b1;
    step();
    checks++;
    if (out1 !== 2'b10 || out2 !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: out1=%b out2=%b required 10/10", out1, out2);
    end
    $display("reset: out1=%b out2=%b", out1, out2);
  endtask

  task automatic test_memwb_op2();
    drive(4'd3, 4'd1, 4'd7, 4'd7, 1'b1);
    step();
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b01) begin
      failures++;
      $display("FAIL memwb_op2: out1=%b out2=%b required 00/01", out1, out2);
    end
    $display("memwb_op2: out1=%b out2=%b", out1, out2);
  endtask

  task automatic test_exmem_op1();
    drive(4'd1, 4'd1, 4'd7, 4'd7, 1'b1);
    step();
    checks++;
    if (out1 !== 2'b10 || out2 !== 2'b01) begin
      failures++;
      $display("FAIL exmem_op1: out1=%b out2=%b required 10/01", out1, out2);
    end
    $display("exmem_op1: out1=%b out2=%b", out1, out2);
  endtask

  task automatic test_memwb_op1_priority();
    drive(4'd2, 4'd1, 4'd7, 4'd1, 1'b1);
    step();
    checks++;
    if (out1 !== 2'b01 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL memwb_op1: out1=%b out2=%b required 01/00", out1, out2);
    end
    $display("memwb_op1: out1=%b out2=%b", out1, out2);
    drive(4'd5, 4'd5, 4'd5, 4'd5, 1'b1);
    step();
    checks++;
    if (out1 !== 2'b10 || out2 !== 2'b10) begin
      failures++;
      $display("FAIL priority: out1=%b out2=%b required 10/10", out1, out2);
    end
    $display("priority: out1=%b out2=%b", out1, out2);
  endtask

  task automatic test_no_hazard();
    drive(4'd2, 4'd1, 4'd1, 4'd3, 1'b1);
    step();
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL no_hazard: out1=%b out2=%b required 00/00", out1, out2);
    end
    $display("no_hazard: out1=%b out2=%b", out1, out2);
    // High bit differs only: exact compare must reject it.
    drive(4'b1001, 4'b0001, 4'b1011, 4'b0011, 1'b1);
    step();
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL exact_compare: out1=%b out2=%b required 00/00", out1, out2);
    end
    $display("exact_compare: out1=%b out2=%b", out1, out2);
  endtask

  task automatic test_write_disable();
    drive(4'd1, 4'd1, 4'd4, 4'd4, 1'b0);
    step();
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL write_disable: out1=%b out2=%b required 00/00", out1, out2);
    end
    $display("write_disable: out1=%b out2=%b", out1, out2);
  endtask

  task automatic test_zero_reg();
    drive(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step();
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL zero_reg_blocked: out1=%b out2=%b required 00/00", out1, out2);
    end
    checks++;
    if (zout1 !== 2'b10 || zout2 !== 2'b10) begin
      failures++;
      $display("FAIL zero_reg_enabled: out1=%b out2=%b required 10/10", zout1, zout2);
    end
    drive(4'd3, 4'd0, 4'd3, 4'd0, 1'b1);
    step();
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b10) begin
      failures++;
      $display("FAIL zero_reg_wb_blocked: out1=%b out2=%b required 00/10", out1, out2);
    end
    checks++;
    if (zout1 !== 2'b01 || zout2 !== 2'b10) begin
      failures++;
      $display("FAIL zero_reg_wb_enabled: out1=%b out2=%b required 01/10", zout1, zout2);
    end
    $display("zero_reg: out=%b/%b zout=%b/%b", out1, out2, zout1, zout2);
  endtask

  task automatic test_latency();
    drive(4'd2, 4'd1, 4'd1, 4'd3, 1'b1);
    step();
    drive(4'd6, 4'd6, 4'd9, 4'd9, 1'b1);
    #3;
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL latency_hold: out1=%b out2=%b required 00/00", out1, out2);
    end
    step();
    checks++;
    if (out1 !== 2'b10 || out2 !== 2'b01) begin
      failures++;
      $display("FAIL latency_update: out1=%b out2=%b required 10/01", out1, out2);
    end
    $display("latency: out1=%b out2=%b", out1, out2);
  endtask

  task automatic test_reset_midop();
    drive(4'd4, 4'd4, 4'd8, 4'd8, 1'b1);
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL reset_midop: out1=%b out2=%b required 00/00", out1, out2);
    end
    step();
    drive(4'd2, 4'd9, 4'd2, 4'd9, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (out1 !== 2'b00 || out2 !== 2'b00) begin
      failures++;
      $display("FAIL reset_release_hold: out1=%b out2=%b required 00/00", out1, out2);
    end
    step();
    checks++;
    if (out1 !== 2'b01 || out2 !== 2'b10) begin
      failures++;
      $display("FAIL reset_reload: out1=%b out2=%b required 01/10", out1, out2);
    end
    $display("reset_midop: out1=%b out2=%b", out1, out2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_memwb_op2();
    test_exmem_op1();
    test_memwb_op1_priority();
    test_no_hazard();
    test_write_disable();
    test_zero_reg();
    test_latency();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
